// File: rtl/img_proc_core_p.sv
// Windowed multi-channel pixel store: bulk load, window origin/depth control,
// window display and per-pixel channel sum/max reduction.
module img_proc_core_p #(
  parameter int  IMG_W  = 8,
  parameter int  IMG_H  = 8,
  parameter int  CH_MAX = 32,
  parameter int  CH_MIN = 8,
  parameter int  DATA_W = 8,
  parameter int  WIN    = 2,
  localparam int OUT_W  = DATA_W + $clog2(CH_MAX)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_op_valid,
  input  logic [3:0]        i_op_mode,
  output logic              o_op_ready,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [OUT_W-1:0]  o_out_data
);
  localparam int CHB   = $clog2(CH_MAX);
  localparam int DW    = CHB + 1;
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);
  localparam int AW    = CHB + RW + CW;
  localparam int LW    = AW + 1;
  localparam int TOTAL = IMG_W * IMG_H * CH_MAX;
  localparam int NW    = $clog2(WIN + 1);

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_SR   = 4'd1;
  localparam logic [3:0] OP_SL   = 4'd2;
  localparam logic [3:0] OP_SU   = 4'd3;
  localparam logic [3:0] OP_SD   = 4'd4;
  localparam logic [3:0] OP_DINC = 4'd5;
  localparam logic [3:0] OP_DDEC = 4'd6;
  localparam logic [3:0] OP_DISP = 4'd7;
  localparam logic [3:0] OP_SUM  = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDY  = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_DISP = 3'd4,
    S_RED  = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_op_ready;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic [RW-1:0]      r_row;
  logic [CW-1:0]      r_col;
  logic [DW-1:0]      r_depth;
  logic [DW-1:0]      r_ch;
  logic [NW-1:0]      r_wr;
  logic [NW-1:0]      r_wc;
  logic [LW-1:0]      r_cnt;
  logic [OUT_W-1:0]   r_acc;
  logic               r_is_max;
  logic               r_tail;
  logic [DATA_W-1:0]  r_mem [TOTAL];

  logic [RW-1:0]      w_row;
  logic [CW-1:0]      w_col;
  logic [AW-1:0]      w_addr;
  logic [DATA_W-1:0]  w_rd;
  logic [OUT_W-1:0]   w_rd_ext;
  logic               w_wr_en;

  // Power-of-two geometry makes the channel-major address a plain concatenation.
  assign w_row    = r_row + RW'(r_wr);
  assign w_col    = r_col + CW'(r_wc);
  assign w_addr   = {r_ch[CHB-1:0], w_row, w_col};
  assign w_rd     = r_mem[w_addr];
  assign w_rd_ext = {{(OUT_W-DATA_W){1'b0}}, w_rd};
  assign w_wr_en  = (r_state == S_LOAD) && r_in_ready && i_in_valid;

  // Pixel store: load byte k lands at linear address k.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_cnt[AW-1:0]] <= i_in_data;
    end
  end

  // Control FSM with window/depth registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_op_ready  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_depth     <= DW'(CH_MAX);
      r_ch        <= '0;
      r_wr        <= '0;
      r_wc        <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_is_max    <= 1'b0;
      r_tail      <= 1'b0;
    end else begin
      r_op_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_RDY;
          r_op_ready <= 1'b1;
        end
        S_RDY: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_op_valid) begin
            r_ch   <= '0;
            r_wr   <= '0;
            r_wc   <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_tail <= 1'b0;
            case (i_op_mode)
              OP_LOAD: begin
                r_state    <= S_LOAD;
                r_in_ready <= 1'b1;
              end
              OP_DISP: r_state <= S_DISP;
              OP_SUM, OP_MAX: begin
                r_state  <= S_RED;
                r_is_max <= (i_op_mode == OP_MAX);
              end
              default: begin
                r_state    <= S_RDY;
                r_op_ready <= 1'b1;
                // Out-of-range moves and depth changes saturate silently.
                case (i_op_mode)
                  OP_SR:   if (r_col < CW'(IMG_W - WIN)) r_col <= r_col + CW'(1);
                  OP_SL:   if (r_col != '0) r_col <= r_col - CW'(1);
                  OP_SU:   if (r_row != '0) r_row <= r_row - RW'(1);
                  OP_SD:   if (r_row < RW'(IMG_H - WIN)) r_row <= r_row + RW'(1);
                  OP_DINC: if (r_depth < DW'(CH_MAX)) r_depth <= r_depth << 1;
                  OP_DDEC: if (r_depth > DW'(CH_MIN)) r_depth <= r_depth >> 1;
                  default: ;
                endcase
              end
            endcase
          end
        end
        S_LOAD: begin
          if (r_tail) begin
            r_state    <= S_RDY;
            r_op_ready <= 1'b1;
            r_tail     <= 1'b0;
          end else if (i_in_valid) begin
            r_cnt <= r_cnt + LW'(1);
            if (r_cnt == LW'(TOTAL - 1)) begin
              r_in_ready <= 1'b0;
              r_tail     <= 1'b1;
            end
          end
        end
        S_DISP: begin
          if (r_tail) begin
            r_state    <= S_RDY;
            r_op_ready <= 1'b1;
            r_tail     <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_ext;
            if (r_wc == NW'(WIN - 1)) begin
              r_wc <= '0;
              if (r_wr == NW'(WIN - 1)) begin
                r_wr <= '0;
                if (r_ch == r_depth - DW'(1)) r_tail <= 1'b1;
                else r_ch <= r_ch + DW'(1);
              end else begin
                r_wr <= r_wr + NW'(1);
              end
            end else begin
              r_wc <= r_wc + NW'(1);
            end
          end
        end
        S_RED: begin
          if (r_tail) begin
            r_state    <= S_RDY;
            r_op_ready <= 1'b1;
            r_tail     <= 1'b0;
          end else if (r_ch == r_depth) begin
            // Extra slot per pixel: emit the finished accumulator and restart.
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
            r_acc       <= '0;
            r_ch        <= '0;
            if (r_wc == NW'(WIN - 1)) begin
              r_wc <= '0;
              if (r_wr == NW'(WIN - 1)) r_tail <= 1'b1;
              else r_wr <= r_wr + NW'(1);
            end else begin
              r_wc <= r_wc + NW'(1);
            end
          end else begin
            r_ch <= r_ch + DW'(1);
            if (r_is_max) r_acc <= (w_rd_ext > r_acc) ? w_rd_ext : r_acc;
            else r_acc <= r_acc + w_rd_ext;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_op_ready  = r_op_ready;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
endmodule

// File: tb/tb_img_proc_core_p.sv
// Directed self-checking bench for img_proc_core_p at default parameters.
module tb_img_proc_core_p;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_op_valid = 1'b0;
  logic [3:0]  i_op_mode = 4'd0;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_in_data = 8'd0;
  logic        o_op_ready;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [12:0] o_out_data;

  img_proc_core_p dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_op_valid(i_op_valid), .i_op_mode(i_op_mode), .o_op_ready(o_op_ready),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl [2048];
  int org_r = 0;
  int org_c = 0;
  int depth = 32;
  int head [8];
  int n_head = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Expects to be in (or reach) the RDY cycle; returns in cycle t+1 after acceptance.
  task automatic issue(input logic [3:0] m);
    for (int i = 0; i < 64; i++) begin
      if (o_op_ready === 1'b1) break;
      step();
    end
    n_cmp++;
    if (o_op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready mode=%0d got op_ready=%b want 1", m, o_op_ready);
    end
    step();
    i_op_valid = 1'b1;
    i_op_mode  = m;
    step();
    i_op_valid = 1'b0;
    i_op_mode  = 4'd0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if (o_op_ready !== 1'b0 || o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_out_data !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b in_rdy=%b vld=%b data=%0d want 0 0 0 0",
               o_op_ready, o_in_ready, o_out_valid, o_out_data);
    end
    i_rst_n = 1'b1;
    n_cmp++;
    if (o_op_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_c1 got op_ready=%b want 0", o_op_ready);
    end
    step();
    n_cmp++;
    if (o_op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_c2 got op_ready=%b want 1", o_op_ready);
    end
  endtask

  task automatic test_op(input logic [3:0] m);
    issue(m);
    n_cmp++;
    if (o_op_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL op_t1 mode=%0d got op_ready=%b vld=%b want 1 0", m, o_op_ready, o_out_valid);
    end
  endtask

  task automatic test_load(input bit gap, input bit alt);
    int k;
    int drops;
    bit ph;
    bit v;
    int b;
    issue(4'd0);
    n_cmp++;
    if (o_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL load_in_ready got %b want 1", o_in_ready);
    end
    k = 0; drops = 0; ph = 1'b1;
    for (int i = 0; i < 8000 && k < 2048; i++) begin
      v  = gap ? ph : 1'b1;
      ph = ~ph;
      b  = alt ? ((k * 7 + 3) % 256) : (k % 256);
      i_in_valid = v;
      i_in_data  = v ? 8'(b) : 8'hA5;
      if (o_in_ready !== 1'b1) drops++;
      if (v && o_in_ready === 1'b1) begin
        mdl[k] = b;
        k++;
      end
      step();
    end
    // A stray byte right after the last one must be ignored.
    i_in_valid = 1'b1;
    i_in_data  = 8'hFF;
    n_cmp++;
    if (k !== 2048 || drops !== 0) begin
      n_bad++;
      $display("FAIL load_count got bytes=%0d ready_drops=%0d want 2048 0", k, drops);
    end
    n_cmp++;
    if (o_in_ready !== 1'b0 || o_op_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL load_end got in_ready=%b op_ready=%b want 0 0", o_in_ready, o_op_ready);
    end
    step();
    i_in_valid = 1'b0;
    n_cmp++;
    if (o_op_ready !== 1'b1 || o_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL load_ready got op_ready=%b in_ready=%b want 1 0", o_op_ready, o_in_ready);
    end
  endtask

  task automatic test_display(input string tag);
    int idx;
    int e;
    issue(4'd7);
    n_cmp++;
    if (o_out_valid !== 1'b0 || o_out_data !== 13'd0) begin
      n_bad++;
      $display("FAIL %s_t1 got vld=%b data=%0d want 0 0", tag, o_out_valid, o_out_data);
    end
    idx = 0;
    for (int ch = 0; ch < depth; ch++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          step();
          e = mdl[ch * 64 + (org_r + r) * 8 + org_c + c];
          n_cmp++;
          if (o_out_valid !== 1'b1 || o_out_data !== 13'(e) || o_op_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_val[%0d] got vld=%b data=%0d rdy=%b want 1 %0d 0",
                     tag, idx, o_out_valid, o_out_data, o_op_ready, e);
          end
          if (idx < n_head) begin
            n_cmp++;
            if (o_out_data !== 13'(head[idx])) begin
              n_bad++;
              $display("FAIL %s_head[%0d] got %0d want %0d", tag, idx, o_out_data, head[idx]);
            end
          end
          idx++;
        end
    step();
    n_cmp++;
    if (o_out_valid !== 1'b0 || o_out_data !== 13'd0 || o_op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_end got vld=%b data=%0d rdy=%b want 0 0 1", tag, o_out_valid, o_out_data, o_op_ready);
    end
    n_head = 0;
  endtask

  task automatic test_reduce(input bit is_max, input int h0, input int h1, input int h2, input int h3);
    int hv [4];
    int got;
    int cyc;
    int e;
    int v;
    int both;
    hv = '{h0, h1, h2, h3};
    issue(is_max ? 4'd9 : 4'd8);
    got = 0; cyc = 1; both = 0;
    for (int i = 0; i < 400 && got < 4; i++) begin
      step();
      cyc++;
      if (o_op_ready === 1'b1) both++;
      if (o_out_valid === 1'b1) begin
        e = 0;
        for (int ch = 0; ch < depth; ch++) begin
          v = mdl[ch * 64 + (org_r + got / 2) * 8 + org_c + got % 2];
          if (is_max) e = (v > e) ? v : e;
          else e = e + v;
        end
        n_cmp++;
        if (cyc !== 1 + (got + 1) * (depth + 1) || o_out_data !== 13'(hv[got]) || o_out_data !== 13'(e)) begin
          n_bad++;
          $display("FAIL reduce%0d_out[%0d] got cyc=%0d data=%0d want cyc=%0d data=%0d model=%0d",
                   is_max, got, cyc, o_out_data, 1 + (got + 1) * (depth + 1), hv[got], e);
        end
        got++;
      end
    end
    n_cmp++;
    if (got !== 4 || both !== 0) begin
      n_bad++;
      $display("FAIL reduce%0d_count got outputs=%0d early_ready=%0d want 4 0", is_max, got, both);
    end
    step();
    n_cmp++;
    if (o_op_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reduce%0d_end got rdy=%b vld=%b want 1 0", is_max, o_op_ready, o_out_valid);
    end
  endtask

  task automatic test_shift();
    test_op(4'd2);
    test_op(4'd3);
    for (int i = 0; i < 7; i++) test_op(4'd1);
    org_r = 0; org_c = 6;
    head[0] = 6; head[1] = 7; head[2] = 14; head[3] = 15; n_head = 4;
    test_display("disp_col6");
    for (int i = 0; i < 7; i++) test_op(4'd4);
    org_r = 6;
    head[0] = 54; head[1] = 55; head[2] = 62; head[3] = 63; n_head = 4;
    test_display("disp_row6");
    for (int i = 0; i < 6; i++) test_op(4'd2);
    for (int i = 0; i < 6; i++) test_op(4'd3);
    org_r = 0; org_c = 0;
  endtask

  task automatic test_reset_mid();
    test_op(4'd4);
    test_op(4'd1);
    test_op(4'd6);
    issue(4'd7);
    for (int i = 0; i < 4; i++) step();
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_out_valid !== 1'b0 || o_out_data !== 13'd0 || o_op_ready !== 1'b0 || o_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async got vld=%b data=%0d rdy=%b in_rdy=%b want 0 0 0 0",
               o_out_valid, o_out_data, o_op_ready, o_in_ready);
    end
    step();
    step();
    i_rst_n = 1'b1;
    n_cmp++;
    if (o_op_ready !== 1'b0 || o_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_c1 got rdy=%b vld=%b want 0 0", o_op_ready, o_out_valid);
    end
    step();
    n_cmp++;
    if (o_op_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_c2 got rdy=%b vld=%b want 1 0", o_op_ready, o_out_valid);
    end
    org_r = 0; org_c = 0; depth = 32;
    head[0] = 3; head[1] = 10; head[2] = 59; head[3] = 66; n_head = 4;
    test_display("disp_after_rst");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load(1'b0, 1'b0);
    head[0] = 0;  head[1] = 1;  head[2] = 8;  head[3] = 9;
    head[4] = 64; head[5] = 65; head[6] = 72; head[7] = 73; n_head = 8;
    test_display("disp_base");
    test_shift();
    for (int i = 0; i < 3; i++) test_op(4'd6);
    depth = 8;
    test_reduce(1'b0, 768, 776, 832, 840);
    test_reduce(1'b1, 192, 193, 200, 201);
    test_op(4'd12);
    head[0] = 0; head[1] = 1; head[2] = 8; head[3] = 9; n_head = 4;
    test_display("disp_noop");
    for (int i = 0; i < 3; i++) test_op(4'd5);
    depth = 32;
    test_load(1'b1, 1'b1);
    head[0] = 3; head[1] = 10; head[2] = 59; head[3] = 66; n_head = 4;
    test_display("disp_gap");
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
